// File: rtl/keyboard_pkg.sv
// Shared definitions for the keyboard event arbiter: event bit layout,
// FSM encoding and the decoder's minimum inter-event gap.
package keyboard_pkg;
  localparam int STB      = 10;
  localparam int PRESS    = 9;
  localparam int EXT      = 8;
  localparam int CODE_MSB = 7;
  localparam int CODE_LSB = 0;
  localparam int EVT_W    = 10;

  localparam int DECODER_MIN_GAP = 9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } kbd_state_t;
endpackage

// File: rtl/kbd_event_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module kbd_event_fifo
  import keyboard_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             CLK_14M,
  input  logic             reset,
  input  logic             i_push,
  input  logic [EVT_W-1:0] i_data,
  input  logic             i_pop,
  output logic [EVT_W-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [EVT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the pointers define validity.
  always_ff @(posedge CLK_14M) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/keyboard_event_arbiter.sv
// Shares the decoder's toggle-strobe input between the PS/2 port (buffered,
// always first) and the injector (paced against the decoder's key-pending flag).
module keyboard_event_arbiter
  import keyboard_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int GAP_CYCLES   = 16,
  parameter int PACE_PASTE   = 1,
  parameter int READ_TIMEOUT = 1400000
) (
  input  logic        CLK_14M,
  input  logic        reset,
  input  logic [10:0] hw_key,
  input  logic        inj_valid,
  output logic        inj_ready,
  input  logic [9:0]  inj_key,
  input  logic        key_pending,
  output logic [10:0] PS2_Key,
  output logic        hw_overflow,
  output logic        busy
);
  localparam int GW = $clog2(GAP_CYCLES);
  localparam int TW = $clog2(READ_TIMEOUT + 1);

  if (GAP_CYCLES <= DECODER_MIN_GAP) begin : g_gap_chk
    $error("GAP_CYCLES must exceed the decoder minimum gap");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  kbd_state_t       r_state;
  kbd_state_t       w_state_nxt;
  logic [GW-1:0]    r_gap_cnt;
  logic [TW-1:0]    r_to_cnt;
  logic             r_pace_wait;
  logic             r_armed;
  logic             r_hw_tog_q;
  logic             r_overflow;
  logic [10:0]      r_ps2_key;
  logic             w_hw_tog;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic [EVT_W-1:0] w_fifo_data;
  logic             w_pop;
  logic             w_inj_ready;
  logic             w_inj_take;
  logic             w_emit;
  logic [EVT_W-1:0] w_emit_evt;

  assign w_hw_tog = r_armed & (hw_key[STB] ^ r_hw_tog_q);

  kbd_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK_14M (CLK_14M),
    .reset   (reset),
    .i_push  (w_hw_tog),
    .i_data  (hw_key[EVT_W-1:0]),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pop | w_inj_take) w_state_nxt = ST_GAP;
      ST_GAP:  if (r_gap_cnt == '0)    w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_inj_ready = 1'b0;
    w_pop       = 1'b0;
    w_inj_take  = 1'b0;
    if (r_state == ST_IDLE) begin
      w_pop       = ~w_fifo_empty;
      w_inj_ready = w_fifo_empty & ~r_pace_wait & r_armed;
      w_inj_take  = w_inj_ready & inj_valid;
    end
  end

  assign w_emit     = w_pop | w_inj_take;
  assign w_emit_evt = w_pop ? w_fifo_data : inj_key;

  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      r_armed     <= 1'b0;
      r_hw_tog_q  <= 1'b0;
      r_overflow  <= 1'b0;
      r_ps2_key   <= '0;
      r_gap_cnt   <= '0;
      r_pace_wait <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_armed    <= 1'b1;
      r_hw_tog_q <= hw_key[STB];
      if (w_hw_tog & w_fifo_full & ~w_pop) r_overflow <= 1'b1;

      if (w_emit)
        r_ps2_key <= {~r_ps2_key[STB], w_emit_evt[PRESS], w_emit_evt[EXT],
                      w_emit_evt[CODE_MSB:CODE_LSB]};

      if (w_emit)
        r_gap_cnt <= GW'(GAP_CYCLES - 1);
      else if ((r_state == ST_GAP) && (r_gap_cnt != '0))
        r_gap_cnt <= r_gap_cnt - 1'b1;

      // Wait is released on the edge where the timeout count reaches zero.
      if (w_inj_take && inj_key[PRESS] && (PACE_PASTE != 0)) begin
        r_pace_wait <= 1'b1;
        r_to_cnt    <= TW'(READ_TIMEOUT - 1);
      end else if (r_pace_wait) begin
        if (((r_state == ST_IDLE) && !key_pending) || (r_to_cnt <= TW'(1)))
          r_pace_wait <= 1'b0;
        if (r_to_cnt != '0) r_to_cnt <= r_to_cnt - 1'b1;
      end
    end
  end

  assign inj_ready   = w_inj_ready;
  assign PS2_Key     = r_ps2_key;
  assign hw_overflow = r_overflow;
  assign busy        = (r_state != ST_IDLE) | ~w_fifo_empty | r_pace_wait;
endmodule

// File: tb/tb_keyboard_event_arbiter.sv
// Scoreboard bench: expected event payloads are queued when driven and
// compared as the decoder strobe toggles; timing is checked by cycle stamps.
module tb_keyboard_event_arbiter;
  logic        CLK_14M = 1'b0;
  logic        reset;
  logic [10:0] hw_key;
  logic        inj_valid;
  logic [9:0]  inj_key;
  logic        key_pending;
  logic        inj_ready;
  logic [10:0] PS2_Key;
  logic        hw_overflow;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_emit   = 0;
  logic [9:0] exp_q[$];
  int         emit_cyc[$];
  logic       prev_tog = 1'b0;

  keyboard_event_arbiter #(
    .FIFO_DEPTH  (8),
    .GAP_CYCLES  (16),
    .PACE_PASTE  (1),
    .READ_TIMEOUT(100)
  ) u_dut (
    .CLK_14M    (CLK_14M),
    .reset      (reset),
    .hw_key     (hw_key),
    .inj_valid  (inj_valid),
    .inj_ready  (inj_ready),
    .inj_key    (inj_key),
    .key_pending(key_pending),
    .PS2_Key    (PS2_Key),
    .hw_overflow(hw_overflow),
    .busy       (busy)
  );

  always #35 CLK_14M = ~CLK_14M;
  always @(posedge CLK_14M) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Decoder-side monitor: every strobe toggle is one emission.
  always @(negedge CLK_14M) begin
    if (reset) prev_tog = 1'b0;
    else if (PS2_Key[10] != prev_tog) begin
      prev_tog = PS2_Key[10];
      n_emit++;
      emit_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("emit_unexpected", {22'd0, PS2_Key[9:0]}, 32'hDEAD_0000);
      else                   chk("emit_data", {22'd0, PS2_Key[9:0]}, {22'd0, exp_q.pop_front()});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK_14M);
      #1;
    end
  endtask

  task automatic hw_evt(input logic [9:0] ev, input bit expected);
    hw_key = {~hw_key[10], ev};
    if (expected) exp_q.push_back(ev);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 2000) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #(70 * 60000);
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb, e, e0, p;
    int ch[$];
    logic t;

    // 1: reset state and single hardware event latency
    reset = 1'b1; hw_key = 11'h21C; inj_valid = 1'b0; inj_key = '0; key_pending = 1'b0;
    tick(3);
    chk("rst_ps2", {21'd0, PS2_Key}, 32'd0);
    chk("rst_ovf", {31'd0, hw_overflow}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, inj_ready}, 32'd0);
    reset = 1'b0;
    tick(2);
    chk("armed_ready", {31'd0, inj_ready}, 32'd1);
    hw_evt(10'h21C, 1'b1);
    tick();
    chk("t1_lat_edge1", {21'd0, PS2_Key}, 32'd0);
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      if (nb == 2) chk("t1_emit", {21'd0, PS2_Key}, 32'h61C);
      tick();
    end
    chk("t1_busy_len", nb, 17);
    chk("t1_ovf", {31'd0, hw_overflow}, 32'd0);

    // 2: burst of ten toggles overflows the 8-deep FIFO
    emit_cyc.delete();
    e0 = n_emit;
    for (int i = 0; i < 10; i++) begin
      hw_evt({2'b10, 8'h30 + 8'(i)}, i < 9);
      tick();
    end
    tick(9 * 17 + 20);
    chk("t2_n_emit", n_emit - e0, 9);
    for (int i = 1; i < emit_cyc.size() && i < 9; i++)
      chk("t2_spacing", emit_cyc[i] - emit_cyc[i-1], 17);
    chk("t2_ovf", {31'd0, hw_overflow}, 32'd1);
    tick(20);
    chk("t2_ovf_sticky", {31'd0, hw_overflow}, 32'd1);
    wait_idle("t2_idle");

    // 3: injected press paced against key_pending
    inj_valid = 1'b1; inj_key = 10'h21C; exp_q.push_back(10'h21C);
    chk("t3_ready", {31'd0, inj_ready}, 32'd1);
    tick();
    e = cyc;
    inj_valid = 1'b0;
    chk("t3_emit", {21'd0, PS2_Key[9:0]}, 32'h21C);
    tick();
    inj_valid = 1'b1; inj_key = 10'h21B; exp_q.push_back(10'h21B);
    for (int k = 2; k <= 60; k++) begin
      tick();
      if (k == 4) key_pending = 1'b1;
      chk("t3_blocked", {31'd0, inj_ready}, 32'd0);
    end
    key_pending = 1'b0;
    chk("t3_blocked_last", {31'd0, inj_ready}, 32'd0);
    tick();
    chk("t3_ready_again", {31'd0, inj_ready}, 32'd1);
    tick();
    inj_valid = 1'b0;
    chk("t3_accept_cyc", cyc - e, 62);
    chk("t3_emit2", {21'd0, PS2_Key[9:0]}, 32'h21B);
    wait_idle("t3_idle");

    // 4: read timeout releases the wait; hardware still served meanwhile
    inj_valid = 1'b1; inj_key = 10'h22A; exp_q.push_back(10'h22A);
    chk("t4_ready", {31'd0, inj_ready}, 32'd1);
    tick();
    e = cyc;
    inj_valid = 1'b0; key_pending = 1'b1;
    tick(29);
    hw_evt(10'h05A, 1'b1);
    tick();
    inj_valid = 1'b1; inj_key = 10'h229; exp_q.push_back(10'h229);
    ch.delete();
    t = PS2_Key[10];
    for (int k = 0; k < 150 && ch.size() < 2; k++) begin
      tick();
      if (PS2_Key[10] != t) begin
        t = PS2_Key[10];
        ch.push_back(cyc);
      end
    end
    inj_valid = 1'b0; key_pending = 1'b0;
    chk("t4_n_emit", ch.size(), 2);
    if (ch.size() == 2) begin
      chk("t4_hw_emit_cyc", ch[0] - e, 31);
      chk("t4_timeout_cyc", ch[1] - e, 100);
    end
    wait_idle("t4_idle");

    // 5: hardware event waiting in the FIFO beats a pending injection
    hw_evt(10'h11E, 1'b1);
    tick();
    p = cyc;
    inj_valid = 1'b1; inj_key = 10'h01E; exp_q.push_back(10'h01E);
    chk("t5_ready_blocked", {31'd0, inj_ready}, 32'd0);
    ch.delete();
    t = PS2_Key[10];
    for (int k = 0; k < 60 && ch.size() < 2; k++) begin
      tick();
      if (PS2_Key[10] != t) begin
        t = PS2_Key[10];
        ch.push_back(cyc);
      end
    end
    inj_valid = 1'b0;
    chk("t5_n_emit", ch.size(), 2);
    if (ch.size() == 2) begin
      chk("t5_hw_first", ch[0] - p, 1);
      chk("t5_inj_after", ch[1] - ch[0], 17);
    end
    wait_idle("t5_idle");

    // 6: reset mid-GAP discards queued events
    hw_evt(10'h070, 1'b1); tick();
    hw_evt(10'h071, 1'b0); tick();
    hw_evt(10'h072, 1'b0); tick();
    hw_evt(10'h073, 1'b0); tick();
    tick(3);
    chk("t6_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    hw_key = {1'b1, hw_key[9:0]};
    #1;
    chk("t6_rst_ps2", {21'd0, PS2_Key}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_ovf", {31'd0, hw_overflow}, 32'd0);
    tick(2);
    reset = 1'b0;
    e0 = n_emit;
    for (int k = 0; k < 17; k++) begin
      tick();
      chk("t6_quiet_busy", {31'd0, busy}, 32'd0);
    end
    chk("t6_no_emit", n_emit - e0, 0);
    chk("t6_ps2_zero", {21'd0, PS2_Key}, 32'd0);
    chk("t6_ready", {31'd0, inj_ready}, 32'd1);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
